// File: rtl/hd44780_responder_pkg.sv
// Shared instruction encodings, command decode and DDRAM address-counter stepping
// for the HD44780 panel-side responder.
package hd44780_responder_pkg;

    localparam int DDRAM_DEPTH = 128;

    // Instruction field masks
    localparam logic [7:0] FS_DL = 8'h10;
    localparam logic [7:0] FS_N  = 8'h08;
    localparam logic [7:0] DC_D  = 8'h04;
    localparam logic [7:0] DC_C  = 8'h02;
    localparam logic [7:0] DC_B  = 8'h01;
    localparam logic [7:0] EM_ID = 8'h02;
    localparam logic [7:0] SDL_ADDR = 8'h7F;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_e;

    // Instruction class is selected by the highest set bit.
    function automatic cmd_e decode_cmd(input logic [7:0] b);
        casez (b)
            8'b1???????: return CMD_DDRAM;
            8'b01??????: return CMD_CGRAM;
            8'b001?????: return CMD_FUNC;
            8'b0001????: return CMD_SHIFT;
            8'b00001???: return CMD_DISPLAY;
            8'b000001??: return CMD_ENTRY;
            8'b0000001?: return CMD_HOME;
            8'b00000001: return CMD_CLEAR;
            default:     return CMD_NOP;
        endcase
    endfunction

    // Two-line layout wraps 0x27<->0x40 and 0x67<->0x00; one-line wraps 0x4F<->0x00.
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up,
                                           input logic two);
        if (two) begin
            if (up) begin
                if (a == 7'h27) return 7'h40;
                if (a == 7'h67) return 7'h00;
                return a + 7'd1;
            end
            if (a == 7'h00) return 7'h67;
            if (a == 7'h40) return 7'h27;
            return a - 7'd1;
        end
        if (up) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

endpackage

// File: rtl/hd44780_responder_bus_sync.sv
// Multi-stage synchronizer for the asynchronous {e, rs, db} bus plus a falling-edge
// pulse on the synchronized enable.
module hd44780_responder_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    output logic       rs_sync,
    output logic [3:0] db_sync,
    output logic       e_fall
);

    logic [5:0] stage [SYNC_STAGES];
    logic       e_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            e_last <= 1'b0;
        end else begin
            stage[0] <= {e, rs, db};
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            e_last <= stage[SYNC_STAGES-1][5];
        end
    end

    assign rs_sync = stage[SYNC_STAGES-1][4];
    assign db_sync = stage[SYNC_STAGES-1][3:0];
    assign e_fall  = e_last & ~stage[SYNC_STAGES-1][5];

endmodule

// File: rtl/hd44780_responder.sv
// Panel-side HD44780 responder: rebuilds bus bytes, executes the instruction subset
// and mirrors character writes into a 128x8 DDRAM with a registered read port.
module hd44780_responder
    import hd44780_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLR_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       bus4,
    output logic       two_line,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc,
    output logic [6:0] ac,
    output logic       instr_strobe,
    output logic       data_strobe,
    output logic       err
);

    logic       e_fall, rs_s;
    logic [3:0] db_s;
    logic       phase_low, hi_rs, cg_mode;
    logic [3:0] hi_nib;
    logic [6:0] fill_addr;
    logic [7:0] mem [DDRAM_DEPTH];

    logic       byte_done, cur_rs, rs_err, exec, wr_en;
    logic [7:0] cur_byte, wr_data;
    logic [6:0] wr_addr;
    cmd_e       cmd;

    hd44780_responder_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .e      (e),
        .rs     (rs),
        .db     (db),
        .rs_sync(rs_s),
        .db_sync(db_s),
        .e_fall (e_fall)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        byte_done = e_fall && (!bus4 || phase_low);
        cur_byte  = bus4 ? {hi_nib, db_s} : {db_s, 4'h0};
        cur_rs    = bus4 ? hi_rs : rs_s;
        rs_err    = e_fall && bus4 && phase_low && (rs_s != hi_rs);
        exec      = byte_done && !busy;
        cmd       = decode_cmd(cur_byte);
        wr_en     = busy || (exec && cur_rs && !cg_mode);
        wr_addr   = busy ? fill_addr : ac;
        wr_data   = busy ? CLR_CHAR : cur_byte;
    end

    // NOTE: sequential state uses non-blocking assignments; later assignments win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b1;
            fill_addr    <= '0;
            bus4         <= 1'b0;
            two_line     <= 1'b0;
            disp_on      <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            inc          <= 1'b1;
            ac           <= '0;
            instr_strobe <= 1'b0;
            data_strobe  <= 1'b0;
            err          <= 1'b0;
            phase_low    <= 1'b0;
            hi_nib       <= '0;
            hi_rs        <= 1'b0;
            cg_mode      <= 1'b0;
        end else begin
            instr_strobe <= 1'b0;
            data_strobe  <= 1'b0;

            if (busy) begin
                fill_addr <= fill_addr + 7'd1;
                if (fill_addr == 7'h7F) busy <= 1'b0;
            end

            // The nibble phase advances on every edge, even while busy.
            if (e_fall && bus4) begin
                phase_low <= ~phase_low;
                if (!phase_low) begin
                    hi_nib <= db_s;
                    hi_rs  <= rs_s;
                end
            end

            if ((e_fall && busy) || rs_err) err <= 1'b1;

            if (exec && cur_rs) begin
                data_strobe <= 1'b1;
                if (!cg_mode) ac <= step_ac(ac, inc, two_line);
            end else if (exec) begin
                instr_strobe <= 1'b1;
                case (cmd)
                    CMD_CLEAR: begin
                        busy      <= 1'b1;
                        fill_addr <= '0;
                        ac        <= '0;
                        inc       <= 1'b1;
                    end
                    CMD_HOME:  ac <= '0;
                    CMD_ENTRY: inc <= |(cur_byte & EM_ID);
                    CMD_DISPLAY: begin
                        disp_on   <= |(cur_byte & DC_D);
                        cursor_on <= |(cur_byte & DC_C);
                        blink_on  <= |(cur_byte & DC_B);
                    end
                    CMD_FUNC: begin
                        bus4     <= ~|(cur_byte & FS_DL);
                        two_line <= |(cur_byte & FS_N);
                        if ((~|(cur_byte & FS_DL)) != bus4) phase_low <= 1'b0;
                    end
                    CMD_CGRAM: cg_mode <= 1'b1;
                    CMD_DDRAM: begin
                        ac      <= cur_byte[6:0] & SDL_ADDR[6:0];
                        cg_mode <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the DDRAM array has no reset; the clear fill initialises it after reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed self-checking bench for hd44780_responder: fill, init, data writes,
// line wrap, busy drop and nibble rs mismatch with reset mid-fill.
module tb_hd44780_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] db = 4'h0;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic       busy, bus4, two_line, disp_on, cursor_on, blink_on, inc;
    logic [6:0] ac;
    logic       instr_strobe, data_strobe, err;

    int tests = 0;
    int fails = 0;
    int icnt = 0;
    int dcnt = 0;

    hd44780_responder #(.SYNC_STAGES(2), .CLR_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst_n), .e(e), .rs(rs), .db(db),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .bus4(bus4),
        .two_line(two_line), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .inc(inc), .ac(ac),
        .instr_strobe(instr_strobe), .data_strobe(data_strobe), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (instr_strobe) icnt <= icnt + 1;
        if (data_strobe)  dcnt <= dcnt + 1;
    end

    task automatic send_nibble(input logic r, input logic [3:0] n);
        @(negedge clk);
        rs = r; db = n; e = 1'b1;
        repeat (4) @(negedge clk);
        e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_byte4(input logic r, input logic [7:0] b);
        send_nibble(r, b[7:4]);
        send_nibble(r, b[3:0]);
    endtask

    task automatic read_mem(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_mem(input string name, input logic [6:0] a, input logic [7:0] exp);
        logic [7:0] d;
        read_mem(a, d);
        tests++;
        if (d !== exp) begin
            fails++;
            $display("FAIL %s: DDRAM[%02h] got %02h expected %02h", name, a, d, exp);
        end
    endtask

    task automatic check_all_clear(input string name);
        int bad = 0;
        logic [7:0] d;
        for (int i = 0; i < 128; i++) begin
            read_mem(7'(i), d);
            if (d !== 8'h20) begin
                if (bad == 0) $display("FAIL %s: DDRAM[%02h] got %02h expected 20", name, i, d);
                bad++;
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    // Counts posedges from the current point until busy is seen low.
    task automatic wait_fill(input string name, input int exp_cycles);
        int n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (!busy) break;
        end
        tests++;
        if (busy !== 1'b0 || (exp_cycles > 0 && n != exp_cycles)) begin
            fails++;
            $display("FAIL %s: busy=%b after %0d cycles, expected 0 after %0d",
                     name, busy, n, exp_cycles);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({rd_data, busy, bus4, two_line, disp_on, cursor_on, blink_on, inc, ac,
             instr_strobe, data_strobe, err} !== {8'h00, 7'b1000001, 7'h00, 3'b000}) begin
            fails++;
            $display("FAIL reset_values: rd=%02h busy=%b bus4=%b n=%b d/c/b=%b%b%b inc=%b ac=%02h err=%b",
                     rd_data, busy, bus4, two_line, disp_on, cursor_on, blink_on, inc, ac, err);
        end
        wait_fill("reset_fill_len", 128);
        check_all_clear("reset_fill_data");
    endtask

    task automatic run_init();
        send_nibble(1'b0, 4'h2);
        send_byte4(1'b0, 8'h28);
        send_byte4(1'b0, 8'h0C);
        send_byte4(1'b0, 8'h06);
    endtask

    task automatic test_init();
        int i0 = icnt;
        run_init();
        tests++;
        if ({bus4, two_line, disp_on, cursor_on, blink_on, inc} !== 6'b111001) begin
            fails++;
            $display("FAIL init_flags: bus4=%b n=%b d=%b c=%b b=%b inc=%b expected 1 1 1 0 0 1",
                     bus4, two_line, disp_on, cursor_on, blink_on, inc);
        end
        tests++;
        if (icnt - i0 != 4) begin
            fails++;
            $display("FAIL init_strobes: got %0d expected 4", icnt - i0);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL init_err: got %b expected 0", err);
        end
    endtask

    task automatic test_data();
        int d0 = dcnt;
        send_byte4(1'b0, 8'h80);
        send_byte4(1'b1, 8'h48);
        send_byte4(1'b1, 8'h69);
        tests++;
        if (ac !== 7'h02) begin
            fails++;
            $display("FAIL data_ac: got %02h expected 02", ac);
        end
        tests++;
        if (dcnt - d0 != 2) begin
            fails++;
            $display("FAIL data_strobes: got %0d expected 2", dcnt - d0);
        end
        check_mem("data_h", 7'h00, 8'h48);
        check_mem("data_i", 7'h01, 8'h69);
    endtask

    task automatic test_line_wrap();
        send_byte4(1'b0, 8'hA7);
        send_byte4(1'b1, 8'h41);
        send_byte4(1'b1, 8'h42);
        tests++;
        if (ac !== 7'h41) begin
            fails++;
            $display("FAIL wrap_ac: got %02h expected 41", ac);
        end
        check_mem("wrap_27", 7'h27, 8'h41);
        check_mem("wrap_40", 7'h40, 8'h42);
        send_byte4(1'b0, 8'hE7);
        send_byte4(1'b1, 8'h43);
        tests++;
        if (ac !== 7'h00) begin
            fails++;
            $display("FAIL wrap_end_ac: got %02h expected 00", ac);
        end
        check_mem("wrap_67", 7'h67, 8'h43);
        // Decrement across the start of line 1
        send_byte4(1'b0, 8'h04);
        send_byte4(1'b0, 8'h80);
        send_byte4(1'b1, 8'h44);
        tests++;
        if (ac !== 7'h67 || inc !== 1'b0) begin
            fails++;
            $display("FAIL dec_wrap: ac=%02h inc=%b expected 67 0", ac, inc);
        end
        check_mem("dec_00", 7'h00, 8'h44);
        send_byte4(1'b0, 8'h06);
    endtask

    task automatic test_busy_drop();
        int i0, d0;
        send_byte4(1'b0, 8'h01);
        i0 = icnt;
        d0 = dcnt;
        tests++;
        if (busy !== 1'b1 || ac !== 7'h00 || inc !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL clear_start: busy=%b ac=%02h inc=%b err=%b expected 1 00 1 0",
                     busy, ac, inc, err);
        end
        send_byte4(1'b1, 8'h55);
        tests++;
        if (err !== 1'b1 || dcnt != d0 || icnt != i0) begin
            fails++;
            $display("FAIL busy_drop: err=%b strobes=%0d/%0d expected 1 0/0",
                     err, icnt - i0, dcnt - d0);
        end
        wait_fill("clear_fill_end", 0);
        tests++;
        if (ac !== 7'h00) begin
            fails++;
            $display("FAIL busy_drop_ac: got %02h expected 00", ac);
        end
        check_all_clear("clear_fill_data");
    endtask

    task automatic test_rs_mismatch();
        int d0;
        do_reset();
        wait_fill("refill_len", 128);
        run_init();
        d0 = dcnt;
        send_nibble(1'b1, 4'h4);
        send_nibble(1'b0, 4'h8);
        tests++;
        if (err !== 1'b1 || dcnt - d0 != 1 || ac !== 7'h01) begin
            fails++;
            $display("FAIL rs_mismatch: err=%b dstrobes=%0d ac=%02h expected 1 1 01",
                     err, dcnt - d0, ac);
        end
        check_mem("rs_mismatch_data", 7'h00, 8'h48);
        send_byte4(1'b0, 8'h01);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, bus4, two_line, disp_on, err, ac} !== {5'b10000, 7'h00}) begin
            fails++;
            $display("FAIL midfill_reset: busy=%b bus4=%b n=%b d=%b err=%b ac=%02h",
                     busy, bus4, two_line, disp_on, err, ac);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fill("midfill_restart_len", 128);
        check_all_clear("midfill_restart_data");
    endtask

    initial begin
        test_reset();
        test_init();
        test_data();
        test_line_wrap();
        test_busy_drop();
        test_rs_mismatch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
